// File: rtl/gr8b0nd_exec_ctrl.sv
// Multicycle decode/execute sequencer for the gr8b0nd core.
// Owns the 16x16 register file and drives the external combinational ALU and data memory.
module gr8b0nd_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic [15:0] i_instr,
  output logic        o_instr_ready,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  output logic [7:0]  o_alu_select,
  input  logic [15:0] i_alu_out,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_br_taken,
  output logic        o_br_abs,
  output logic [15:0] o_br_target,
  output logic        o_retire,
  output logic        o_halted
);

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_regs [16];
  logic [15:0] r_result;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [7:0]  r_alu_sel;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_mem_done;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_br_taken;
  logic        r_br_abs;
  logic [15:0] r_br_target;
  logic        r_retire;

  logic [7:0]  w_op8;
  logic [3:0]  w_op4;
  logic [3:0]  w_rs;
  logic [3:0]  w_rd;
  logic [7:0]  w_imm8;
  logic [15:0] w_rs_val;
  logic [15:0] w_rd_val;
  logic [15:0] w_imm_sext;
  logic        w_is_alu;
  logic        w_is_unary;

  assign w_op8      = r_ir[15:8];
  assign w_op4      = r_ir[15:12];
  assign w_rs       = r_ir[7:4];
  assign w_rd       = r_ir[3:0];
  assign w_imm8     = r_ir[11:4];
  assign w_rs_val   = r_regs[w_rs];
  assign w_rd_val   = r_regs[w_rd];
  assign w_imm_sext = {{8{w_imm8[7]}}, w_imm8};
  assign w_is_alu   = w_op8 inside {[8'h50:8'h52], [8'h60:8'h63], [8'h70:8'h77]};
  assign w_is_unary = w_op8 inside {8'h10, 8'h32, 8'h33};

  assign o_instr_ready = (r_state == StIdle);
  assign o_halted      = (r_state == StHalt);
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_select  = r_alu_sel;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_br_taken    = r_br_taken;
  assign o_br_abs      = r_br_abs;
  assign o_br_target   = r_br_target;
  assign o_retire      = r_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ir        <= '0;
      r_result    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_done  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_br_taken  <= 1'b0;
      r_br_abs    <= 1'b0;
      r_br_target <= '0;
      r_retire    <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_br_taken <= 1'b0;
      r_retire   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_instr_valid) begin
            r_ir    <= i_instr;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          // op4 classes (constants, branches) take priority over op8 decode.
          if (w_op4 == 4'hb) begin
            r_result <= w_imm_sext;
            r_state  <= StWb;
          end else if (w_op4 == 4'hc) begin
            r_result <= {w_imm8, w_imm8};
            r_state  <= StWb;
          end else if (w_op4 == 4'hd) begin
            r_result <= {w_imm8, w_rd_val[7:0]};
            r_state  <= StWb;
          end else if (w_op4 == 4'he || w_op4 == 4'hf) begin
            if ((w_rd_val == 16'h0) == (w_op4 == 4'he)) begin
              r_br_taken  <= 1'b1;
              r_br_abs    <= 1'b0;
              r_br_target <= w_imm_sext;
            end
            r_retire <= 1'b1;
            r_state  <= StIdle;
          end else if (w_is_alu || w_is_unary) begin
            r_alu_a   <= w_is_alu ? w_rs_val : 16'h0;
            r_alu_b   <= w_rd_val;
            r_alu_sel <= w_op8;
            r_state   <= StExec;
          end else if (w_op8 == 8'h40 || w_op8 == 8'h41) begin
            r_mem_addr  <= w_rs_val;
            r_mem_wdata <= w_rd_val;
            r_mem_we    <= w_op8[0];
            r_state     <= StMem;
          end else if (w_op8 == 8'h01) begin
            r_br_taken  <= 1'b1;
            r_br_abs    <= 1'b1;
            r_br_target <= w_rd_val;
            r_retire    <= 1'b1;
            r_state     <= StIdle;
          end else if (w_op8 == 8'h00) begin
            r_retire <= 1'b1;
            r_state  <= StHalt;
          end else begin
            r_retire <= 1'b1;
            r_state  <= StIdle;
          end
        end
        StExec: begin
          r_result <= i_alu_out;
          r_state  <= StWb;
        end
        StMem: begin
          // Three phases: issue request, wait for ack, then complete from the latched ack.
          if (r_mem_done) begin
            r_mem_done <= 1'b0;
            if (r_mem_we) begin
              r_retire <= 1'b1;
              r_state  <= StIdle;
            end else begin
              r_state <= StWb;
            end
          end else if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (i_mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_done <= 1'b1;
            r_result   <= i_mem_rdata;
          end
        end
        StWb: begin
          r_regs[w_rd] <= r_result;
          r_retire     <= 1'b1;
          r_state      <= StIdle;
        end
        StHalt: r_state <= StHalt;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gr8b0nd_exec_ctrl.sv
// Directed plus randomized bench for gr8b0nd_exec_ctrl against an instruction-level model.
module tb_gr8b0nd_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [7:0]  alu_select;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        br_taken, br_abs, retire, halted;
  logic [15:0] br_target;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_reg [16];

  always #5 clk = ~clk;

  // External ALU stand-in; addi (0x70) is a plain add.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] s);
    if (s == 8'h70) return a + b;
    return (a ^ {s, s}) + (b << 1);
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_select);

  gr8b0nd_exec_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_instr_valid(instr_valid),
    .i_instr      (instr),
    .o_instr_ready(instr_ready),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_select (alu_select),
    .i_alu_out    (alu_out),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ack    (mem_ack),
    .o_br_taken   (br_taken),
    .o_br_abs     (br_abs),
    .o_br_target  (br_target),
    .o_retire     (retire),
    .o_halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction, act as ALU/memory, and check against the model.
  task automatic issue(input logic [15:0] ins, input int d, input logic [15:0] rv);
    logic [7:0]  op8;
    logic [3:0]  op4, rs, rd;
    logic [7:0]  imm;
    logic [15:0] sx, wv, btgt, ea, eb;
    int          lat, waited, ret_cyc, reqcnt;
    bit          wr, br, babs, isexe, ismem, halt;
    op8 = ins[15:8]; op4 = ins[15:12]; rs = ins[7:4]; rd = ins[3:0]; imm = ins[11:4];
    sx = {{8{imm[7]}}, imm};
    wr = 0; br = 0; babs = 0; isexe = 0; ismem = 0; halt = 0;
    wv = '0; btgt = '0; ea = '0; eb = '0; lat = 1;
    if (op4 == 4'hb || op4 == 4'hc || op4 == 4'hd) begin
      lat = 2; wr = 1;
      wv = (op4 == 4'hb) ? sx : (op4 == 4'hc) ? {imm, imm} : {imm, m_reg[rd][7:0]};
    end else if (op4 >= 4'he) begin
      br = (op4 == 4'he) ? (m_reg[rd] == 0) : (m_reg[rd] != 0);
      btgt = sx;
    end else if ((op8 >= 8'h50 && op8 <= 8'h52) || (op8 >= 8'h60 && op8 <= 8'h63) ||
                 (op8 >= 8'h70 && op8 <= 8'h77) || op8 == 8'h10 || op8 == 8'h32 ||
                 op8 == 8'h33) begin
      isexe = 1; lat = 3; wr = 1;
      ea = (op8 >= 8'h50) ? m_reg[rs] : 16'h0;
      eb = m_reg[rd];
      wv = alu_f(ea, eb, op8);
    end else if (op8 == 8'h40 || op8 == 8'h41) begin
      ismem = 1;
      wr = (op8 == 8'h40);
      lat = wr ? d + 5 : d + 4;
      wv = rv;
    end else if (op8 == 8'h01) begin
      br = 1; babs = 1; btgt = m_reg[rd];
    end else if (op8 == 8'h00) begin
      halt = 1;
    end
    waited = 0;
    while (!instr_ready && waited < 20) begin
      tick();
      waited++;
    end
    // Stray ack while idle must be ignored.
    mem_ack = 1'($urandom_range(0, 1));
    instr_valid = 1'b1;
    instr = ins;
    tick();
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    chk("ready_low_after_accept", {31'b0, instr_ready}, 32'h0);
    ret_cyc = -1;
    reqcnt = 0;
    for (int cyc = 1; cyc <= lat + 20; cyc++) begin
      if (cyc > 1) tick();
      else begin
        @(posedge clk);
        #1;
      end
      mem_ack = 1'b0;
      if (cyc == 1) begin
        chk("br_taken", {31'b0, br_taken}, {31'b0, br});
        if (br) begin
          chk("br_abs", {31'b0, br_abs}, {31'b0, babs});
          chk("br_target", {16'b0, br_target}, {16'b0, btgt});
        end
        if (isexe) begin
          chk("alu_a", {16'b0, alu_a}, {16'b0, ea});
          chk("alu_b", {16'b0, alu_b}, {16'b0, eb});
          chk("alu_select", {24'b0, alu_select}, {24'b0, op8});
        end
        if (ismem) chk("mem_req_c1", {31'b0, mem_req}, 32'h0);
      end
      if (ismem && mem_req) begin
        reqcnt++;
        if (cyc == 2) begin
          chk("mem_addr", {16'b0, mem_addr}, {16'b0, m_reg[rs]});
          chk("mem_we", {31'b0, mem_we}, {31'b0, !wr});
          if (!wr) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_reg[rd]});
        end
      end
      if (ismem && cyc == 2 + d) begin
        mem_ack = 1'b1;
        mem_rdata = rv;
      end
      if (retire) begin
        ret_cyc = cyc;
        break;
      end
    end
    mem_ack = 1'b0;
    chk($sformatf("retire_lat_%04h", ins), ret_cyc, lat);
    if (ismem) chk("mem_req_cycles", reqcnt, d + 1);
    if (halt) chk("halted_after_trap", {31'b0, halted}, 32'h1);
    if (wr) m_reg[rd] = wv;
  endtask

  task automatic check_reg(input logic [3:0] r, input logic [15:0] v);
    issue({8'h01, 4'h0, r}, 0, 16'h0);
    chk($sformatf("reg_r%0d", r), {16'b0, br_target}, {16'b0, v});
  endtask

  function automatic logic [15:0] rand_instr();
    logic [7:0] alu_ops [13];
    alu_ops = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62, 8'h63,
                8'h70, 8'h71, 8'h74, 8'h77, 8'h10, 8'h33};
    case ($urandom_range(0, 6))
      0: return {4'($urandom_range(11, 13)), 12'($urandom)};
      1: return {4'($urandom_range(14, 15)), 12'($urandom)};
      2, 3: return {alu_ops[$urandom_range(0, 12)], 8'($urandom)};
      4: return {8'h40 + 8'($urandom_range(0, 1)), 8'($urandom)};
      5: return {8'h01, 8'($urandom)};
      default: return {8'($urandom_range(2, 8'haf)), 8'($urandom)};
    endcase
  endfunction

  initial begin
    logic [15:0] ri;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    repeat (3) tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'b0, instr_ready}, 32'h1);
    chk("rst_retire", {31'b0, retire}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_br_taken", {31'b0, br_taken}, 32'h0);
    chk("rst_alu_a", {16'b0, alu_a}, 32'h0);
    chk("rst_alu_sel", {24'b0, alu_select}, 32'h0);
    chk("rst_br_target", {16'b0, br_target}, 32'h0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);

    issue(16'hb051, 0, 0);  check_reg(1, 16'h0005);
    issue(16'hbff2, 0, 0);  check_reg(2, 16'hffff);
    issue(16'hb091, 0, 0);
    issue(16'hb032, 0, 0);
    issue(16'h7012, 0, 0);  check_reg(2, 16'h000c);
    issue(16'hc123, 0, 0);  check_reg(3, 16'h1212);
    issue(16'hdab3, 0, 0);  check_reg(3, 16'hab12);
    issue(16'hb401, 0, 0);
    issue(16'h4014, 2, 16'hbeef); check_reg(4, 16'hbeef);
    issue(16'h4114, 0, 16'h0);
    issue(16'hb005, 0, 0);
    issue(16'hefc5, 0, 0);
    chk("bz_taken_target", {16'b0, br_target}, 32'hfffc);
    issue(16'hb015, 0, 0);
    issue(16'hefc5, 0, 0);

    for (int n = 0; n < 250; n++) begin
      ri = rand_instr();
      issue(ri, $urandom_range(0, 4), 16'($urandom));
    end
    for (int r = 0; r < 16; r++) check_reg(4'(r), m_reg[r]);

    issue(16'h0000, 0, 0);
    instr_valid = 1'b1;
    instr = 16'hb051;
    repeat (4) tick();
    chk("halt_ready", {31'b0, instr_ready}, 32'h0);
    chk("halt_retire", {31'b0, retire}, 32'h0);
    chk("halt_sticky", {31'b0, halted}, 32'h1);
    chk("halt_no_mem", {31'b0, mem_req}, 32'h0);
    instr_valid = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    issue(16'hb401, 0, 0);
    issue(16'hb7f4, 0, 0);
    instr_valid = 1'b1;
    instr = 16'h4014;
    tick();
    instr_valid = 1'b0;
    repeat (2) tick();
    chk("pend_ld_req", {31'b0, mem_req}, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("async_rst_halted", {31'b0, halted}, 32'h0);
    chk("async_rst_ready", {31'b0, instr_ready}, 32'h1);
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) check_reg(4'(r), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gr8b0nd_exec_ctrl.md
# gr8b0nd_exec_ctrl

Multicycle decode/execute sequencer for the gr8b0nd core. It sits directly upstream of the combinational ALU and owns the 16 x 16-bit register file. It accepts one instruction at a time from fetch and drives the ALU operands and select. It captures the ALU result and writes it back, and it also sequences loads/stores, constants, branches and trap.

## Interface
- No parameters; word width 16, register count 16 and opcode width 8 are fixed by the ISA.
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  fetch presents an instruction
- `instr`  in  16  instruction word: op8 [15:8], op4 [15:12], rs [7:4], rd [3:0], imm8 [11:4]
- `instr_ready`  out  1  high only in IDLE and not halted
- `alu_a`  out  16  ALU source operand (registered)
- `alu_b`  out  16  ALU destination operand (registered)
- `alu_select`  out  8  ALU opcode (registered op8)
- `alu_out`  in  16  ALU result (combinational from alu_a/alu_b/alu_select)
- `mem_req`  out  1  data memory request, held until ack
- `mem_we`  out  1  1 = store
- `mem_addr`  out  16  address = reg[rs]
- `mem_wdata`  out  16  store data = reg[rd]
- `mem_rdata`  in  16  load data, valid with mem_ack
- `mem_ack`  in  1  one-cycle completion
- `br_taken`  out  1  one-cycle pulse: redirect fetch
- `br_abs`  out  1  with br_taken: 1 = absolute target (jr), 0 = PC-relative offset
- `br_target`  out  16  target/offset, valid with br_taken
- `retire`  out  1  one-cycle pulse per completed instruction
- `halted`  out  1  set by trap, sticky until reset

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- IDLE: on `instr_valid && instr_ready`, latch `instr` into IR and go to DECODE.
- DECODE: read reg[rs] and reg[rd]; classify by op4 first, then by op8.
  - ALU class (op8 0x50–0x52, 0x60–0x63, 0x70–0x77): alu_a=reg[rs], alu_b=reg[rd], alu_select=op8; go to EXEC.
  - Unary class (0x10 not, 0x32 negi, 0x33 negii): alu_a=0, alu_b=reg[rd]; go to EXEC.
  - Load/store (0x40 ld, 0x41 st): go to MEM.
  - Constants; all go to WB with value V:
    - ci8 (op4 0xb): V = sign-extend(imm8).
    - cii (0xc): V = {imm8, imm8}.
    - cup (0xd): V = {imm8, reg[rd][7:0]}.
  - bz (op4 0xe) / bnz (0xf):
    - Condition is reg[rd]==0 for bz and !=0 for bnz.
    - If true, pulse br_taken with br_abs=0 and br_target = sign-extend(imm8).
    - Either way, pulse retire and go to IDLE.
  - jr (0x01): pulse br_taken, br_abs=1, br_target=reg[rd], retire, go to IDLE.
  - trap (0x00): pulse retire, go to HALT.
  - Any other opcode (0x2x, 0x30, 0x31, unlisted): no-op, retire, go to IDLE.
- EXEC: capture alu_out into result register; go to WB.
- MEM: hold mem_req=1 with stable addr/we/wdata until mem_ack.
  - On ack with ld: capture mem_rdata and go to WB.
  - On ack with st: retire and go to IDLE.
- WB: write result to reg[rd], pulse retire, go to IDLE.
- HALT: terminal; instr_ready=0; halted=1; mem_req=0.
- All 16 registers, r0 included, are writable. Only WB writes the register file.

## Timing
- Reset values:
  - State is IDLE.
  - All registers, IR, alu_a, alu_b and alu_select are 0.
  - mem_req, mem_we, br_taken, br_abs, retire and halted are 0.
  - mem_addr, mem_wdata and br_target are 0.
  - instr_ready is 1 after reset release.
- Latency, counting the accept edge as cycle 0:
  - ALU and unary ops: retire in cycle 3; register updated at the end of cycle 3.
  - Constants: retire in cycle 2.
  - Branches, jr, trap and no-ops: retire in cycle 1.
  - Load/store: retire 2 (store) or 3 (load) cycles after the mem_ack cycle; mem_req rises in cycle 2.
- Next accept is possible in the cycle after retire. instr_ready is 0 from the accept edge until IDLE.
- br_taken and retire of a branch assert in the same cycle.
- mem_ack while not in MEM is ignored.
- instr_valid while not ready is ignored; fetch holds it.
- rst_n low mid-operation forces immediate reset state, including mid-MEM: mem_req drops asynchronously and no write-back occurs.

## Test plan
- Reset, then ci8 r1,0x05 → retire at cycle 2, reg[1]=0x0005. Next, ci8 r2,0xFF → reg[2]=0xFFFF.
- Set r1=0x0009 and r2=0x0003, issue addi r2,r1 (0x70) → alu_a=0x0009, alu_b=0x0003, alu_select=0x70 in EXEC; with alu_out modelled as A+B, reg[2]=0x000C at retire in cycle 3.
- cii r3,0x12 then cup r3,0xAB → reg[3]=0x1212, then 0xAB12.
- ld r4,r1 with r1=0x0040, ack delayed 3 cycles with rdata=0xBEEF → mem_req held 3 cycles at addr 0x0040, we=0; reg[4]=0xBEEF.
- bz r5,0xFC with r5=0 → br_taken=1, br_abs=0, br_target=0xFFFC at cycle 1. With r5=1 → no br_taken, retire only.
- trap → retire then halted=1, instr_ready=0, further instr_valid ignored. Assert rst_n low during a pending ld → mem_req=0 immediately, halted=0, all registers 0.
